// File: rtl/sound_pkg.sv
`default_nettype none
// sound_pkg: shared state encoding and default sizes for the speaker PWM path.
package sound_pkg;
  localparam int PWM_BITS_DEF  = 9;
  localparam int MID_LEVEL_DEF = 256;
  localparam int FRAME_LEN     = 1 << PWM_BITS_DEF;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/pwm_frame_counter.sv
`default_nettype none
// pwm_frame_counter: free-running frame counter, frame_start pulse, boundary flag
// and the registered level compare that produces the PWM output.
module pwm_frame_counter
  import sound_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] level,
  output logic                boundary,
  output logic                frame_start,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                frame_start_q, frame_start_d;
  logic                pwm_q, pwm_d;

  // level is the value that applies from the next clock, so the compare uses
  // next-cycle count and the new level is already in effect at cnt==0.
  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    frame_start_d = (cnt_d == '0);
    pwm_d         = (cnt_d < level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      pwm_q         <= pwm_d;
    end
  end

  assign boundary    = (cnt_q == '1);
  assign frame_start = frame_start_q;
  assign pwm_out     = pwm_q;

endmodule
`default_nettype wire

// File: rtl/sound_pwm_out.sv
`default_nettype none
// sound_pwm_out: converts the tone generator sample stream to speaker PWM with
// pop-free ramp-up/ramp-down and amplifier enable control.
module sound_pwm_out
  import sound_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int MID_LEVEL   = MID_LEVEL_DEF,
  parameter int RAMP_FRAMES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] sample,
  input  logic                enable,
  output logic                pwm_out,
  output logic                amp_en,
  output logic                frame_start,
  output logic                running
);

  localparam logic [PWM_BITS-1:0] MID      = PWM_BITS'(MID_LEVEL);
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
  localparam logic [7:0]          DIV_LAST = 8'(RAMP_FRAMES - 1);

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [7:0]          div_q, div_d;
  logic                amp_en_q, amp_en_d;
  logic                running_q;
  logic                boundary;
  logic                step;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    div_d    = div_q;
    amp_en_d = amp_en_q;
    step     = (div_q == DIV_LAST);
    if (boundary) begin
      div_d = step ? 8'd0 : div_q + 8'd1;
      case (state_q)
        ST_OFF: begin
          level_d = '0;
          if (enable) begin
            state_d  = ST_RAMP_UP;
            amp_en_d = 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            state_d = ST_RAMP_DOWN;
          end else if (level_q == MID) begin
            state_d = ST_RUN;
            level_d = sample;
          end else if (step) begin
            level_d = (level_q < MID) ? level_q + 1'b1 : level_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) state_d = ST_RAMP_DOWN;
          else         level_d = sample;
        end
        ST_RAMP_DOWN: begin
          if (enable) begin
            state_d = ST_RAMP_UP;
          end else if (level_q == '0) begin
            state_d  = ST_OFF;
            amp_en_d = 1'b0;
          end else if (step) begin
            level_d = level_q - 1'b1;
            // Amplifier drops at the same boundary the level reaches zero.
            if (level_q == ONE) begin
              state_d  = ST_OFF;
              amp_en_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = ST_OFF;
          level_d  = '0;
          amp_en_d = 1'b0;
        end
      endcase
      if (state_d != state_q) div_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      level_q   <= '0;
      div_q     <= 8'd0;
      amp_en_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      div_q     <= div_d;
      amp_en_q  <= amp_en_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  pwm_frame_counter #(
    .PWM_BITS(PWM_BITS)
  ) u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (level_d),
    .boundary   (boundary),
    .frame_start(frame_start),
    .pwm_out    (pwm_out)
  );

  assign amp_en  = amp_en_q;
  assign running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_pwm_out.sv
`default_nettype none
// tb_sound_pwm_out: directed frame-by-frame checks of PWM duty, ramps and control outputs.
module tb_sound_pwm_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] sample = 9'd400;
  logic       enable = 1'b0;
  logic       en4 = 1'b0;
  logic       pwm_out, amp_en, frame_start, running;
  logic       pwm4, amp4, fs4, run4;
  int         n_pass = 0;
  int         n_total = 0;
  bit         first_frame = 1'b1;

  always #5 clk = ~clk;

  // Midscale lowered to 16 so full ramps fit a short run; frame stays 512 clocks.
  sound_pwm_out #(.PWM_BITS(9), .MID_LEVEL(16), .RAMP_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .enable(enable),
    .pwm_out(pwm_out), .amp_en(amp_en), .frame_start(frame_start), .running(running)
  );

  sound_pwm_out #(.PWM_BITS(9), .MID_LEVEL(16), .RAMP_FRAMES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample(sample), .enable(en4),
    .pwm_out(pwm4), .amp_en(amp4), .frame_start(fs4), .running(run4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Runs one whole frame starting at cnt==0; optionally changes sample after cycle chg_at.
  task automatic run_frame(input bit sel, input int exp_high, input string tag,
                           input int chg_at = -1, input logic [8:0] chg_val = 9'd0);
    int   nhigh = 0;
    int   shape_bad = 0;
    int   fs_bad = 0;
    logic p, f;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      p = sel ? pwm4 : pwm_out;
      f = sel ? fs4 : frame_start;
      if (p === 1'b1) nhigh++;
      if (p !== (i < exp_high)) shape_bad++;
      if (f !== ((i == 0) && !first_frame)) fs_bad++;
      if (i == chg_at) sample = chg_val;
    end
    first_frame = 1'b0;
    check({tag, " high"}, nhigh, exp_high);
    check({tag, " shape"}, shape_bad, 0);
    check({tag, " fstart"}, fs_bad, 0);
  endtask

  initial begin
    #2;
    check("rst pwm", pwm_out, 0);
    check("rst amp", amp_en, 0);
    check("rst running", running, 0);
    check("rst fstart", frame_start, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_frame(0, 0, "off");
    check("off amp", amp_en, 0);
    enable = 1'b1;
    run_frame(0, 0, "enter up");
    check("enter amp", amp_en, 1);
    for (int k = 1; k <= 16; k++) run_frame(0, k, $sformatf("up%0d", k));
    check("up running", running, 0);

    run_frame(0, 400, "run400", 10, 9'd0);
    check("run running", running, 1);
    run_frame(0, 0, "run0", 20, 9'd511);
    run_frame(0, 511, "run511", 5, 9'd100);
    run_frame(0, 100, "midchg", 50, 9'd300);
    run_frame(0, 300, "after midchg", 5, 9'd24);
    run_frame(0, 24, "run24");

    enable = 1'b0;
    sample = 9'd7;
    run_frame(0, 24, "down hold");
    check("down running", running, 0);
    check("down amp", amp_en, 1);
    for (int k = 23; k >= 20; k--) run_frame(0, k, $sformatf("down%0d", k));

    enable = 1'b1;
    sample = 9'd40;
    run_frame(0, 20, "reup hold");
    for (int k = 19; k >= 16; k--) run_frame(0, k, $sformatf("reup%0d", k));
    run_frame(0, 40, "run40");
    check("run40 running", running, 1);

    enable = 1'b0;
    sample = 9'd7;
    run_frame(0, 40, "down40 hold");
    for (int k = 39; k >= 1; k--) run_frame(0, k, $sformatf("dn%0d", k));
    check("last ramp amp", amp_en, 1);
    run_frame(0, 0, "back off");
    check("off again amp", amp_en, 0);
    check("off again running", running, 0);

    enable = 1'b1;
    sample = 9'd300;
    run_frame(0, 0, "enter2");
    for (int k = 1; k <= 16; k++) run_frame(0, k, $sformatf("up2_%0d", k));
    run_frame(0, 300, "run300");

    for (int i = 0; i < 100; i++) @(negedge clk);
    check("pre-rst pwm", pwm_out, 1);
    check("pre-rst running", running, 1);
    check("pre-rst amp", amp_en, 1);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async pwm", pwm_out, 0);
    check("async amp", amp_en, 0);
    check("async running", running, 0);
    check("async fstart", frame_start, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    first_frame = 1'b1;
    run_frame(0, 0, "post rst");
    check("dut4 idle amp", amp4, 0);

    en4 = 1'b1;
    run_frame(1, 0, "r4 enter");
    check("r4 amp", amp4, 1);
    for (int f = 2; f <= 12; f++) run_frame(1, (f - 1) / 4, $sformatf("r4 f%0d", f));
    check("r4 running", run4, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
